// File: rtl/button_conditioner_pkg.sv
// Shared timer constants: button channel indices and 50 MHz default timing.
package timer_pkg;

    localparam int BTN_START   = 0;
    localparam int BTN_STOP    = 1;
    localparam int BTN_DELETE  = 2;
    localparam int BTN_INC_SEC = 3;
    localparam int BTN_INC_MIN = 4;

    localparam int N_BTN_DEFAULT = 5;
    localparam int CLK_HZ        = 50_000_000;

    // 20 ms debounce, 500 ms before the first repeat, 100 ms between repeats
    localparam int DEBOUNCE_CYCLES_DEFAULT = CLK_HZ / 50;
    localparam int REPEAT_DELAY_DEFAULT    = CLK_HZ / 2;
    localparam int REPEAT_PERIOD_DEFAULT   = CLK_HZ / 10;
    localparam logic [4:0] REPEAT_MASK_DEFAULT = 5'b11000;

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_DELAY  = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_conditioner_debounce_channel.sv
// One button channel: 2-flop synchronizer, debounce counter, press-edge pulse
// and optional hold-to-repeat state machine.
module debounce_channel
    import timer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_DEFAULT,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEFAULT,
    parameter bit REPEAT_EN       = 1'b0
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_raw,
    output logic o_level,
    output logic o_pulse
);

    localparam int DB_W    = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int RPT_MAX = max_int(REPEAT_DELAY, REPEAT_PERIOD);
    localparam int RPT_W   = (RPT_MAX > 2) ? $clog2(RPT_MAX) : 1;

    localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

    logic             r_sync_p0;
    logic             r_sync_p1;
    logic             r_level;
    logic             r_pulse;
    logic [DB_W-1:0]  r_db_cnt;
    logic [RPT_W-1:0] r_rpt_cnt;
    rpt_state_t       r_state;

    logic w_toggle;
    logic w_rise;
    logic w_fall;

    function automatic logic [RPT_W-1:0] sat_inc(input logic [RPT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    // The level flips on the edge that completes DEBOUNCE_CYCLES mismatching samples
    assign w_toggle = (r_sync_p1 != r_level) && (r_db_cnt == DB_LAST);
    assign w_rise   = w_toggle && !r_level;
    assign w_fall   = w_toggle && r_level;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync_p0 <= 1'b0;
            r_sync_p1 <= 1'b0;
            r_level   <= 1'b0;
            r_pulse   <= 1'b0;
            r_db_cnt  <= '0;
            r_rpt_cnt <= '0;
            r_state   <= RPT_IDLE;
        end else begin
            // stage p0 -> p1: metastability filter
            r_sync_p0 <= i_raw;
            r_sync_p1 <= r_sync_p0;

            if (r_sync_p1 == r_level) begin
                r_db_cnt <= '0;
            end else if (w_toggle) begin
                r_db_cnt <= '0;
                r_level  <= ~r_level;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end

            r_pulse <= w_rise;

            case (r_state)
                RPT_IDLE: begin
                    if (REPEAT_EN && w_rise) begin
                        r_state   <= RPT_DELAY;
                        r_rpt_cnt <= '0;
                    end
                end
                RPT_DELAY: begin
                    if (w_fall) begin
                        r_state   <= RPT_IDLE;
                        r_rpt_cnt <= '0;
                    end else if (r_rpt_cnt == DELAY_LAST) begin
                        r_pulse   <= 1'b1;
                        r_rpt_cnt <= '0;
                        r_state   <= RPT_REPEAT;
                    end else begin
                        r_rpt_cnt <= sat_inc(r_rpt_cnt);
                    end
                end
                RPT_REPEAT: begin
                    if (w_fall) begin
                        r_state   <= RPT_IDLE;
                        r_rpt_cnt <= '0;
                    end else if (r_rpt_cnt == PERIOD_LAST) begin
                        r_pulse   <= 1'b1;
                        r_rpt_cnt <= '0;
                    end else begin
                        r_rpt_cnt <= sat_inc(r_rpt_cnt);
                    end
                end
                default: begin
                    r_state   <= RPT_IDLE;
                    r_rpt_cnt <= '0;
                end
            endcase
        end
    end

    assign o_level = r_level;
    assign o_pulse = r_pulse;

endmodule

// File: rtl/button_conditioner.sv
// Push-button front end: one independent debounce/repeat channel per button.
module button_conditioner
    import timer_pkg::*;
#(
    parameter int               N_BTN           = N_BTN_DEFAULT,
    parameter int               DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int               REPEAT_DELAY    = REPEAT_DELAY_DEFAULT,
    parameter int               REPEAT_PERIOD   = REPEAT_PERIOD_DEFAULT,
    parameter logic [N_BTN-1:0] REPEAT_MASK     = N_BTN'(REPEAT_MASK_DEFAULT)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_pulse
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD),
            .REPEAT_EN       (REPEAT_MASK[i])
        ) u_chan (
            .i_clk   (clk),
            .i_reset (reset),
            .i_raw   (btn_raw[i]),
            .o_level (btn_level[i]),
            .o_pulse (btn_pulse[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: segment table, directed corner cases and a
// randomized run, all compared each cycle against a window-based reference model.
module tb_button_conditioner;

    localparam int         N    = 5;
    localparam int         DB   = 4;
    localparam int         RD   = 10;
    localparam int         RP   = 3;
    localparam logic [4:0] MASK = 5'b11000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] btn_raw = '0;
    logic [4:0] btn_level;
    logic [4:0] btn_pulse;

    always #5 clk = ~clk;

    button_conditioner #(
        .N_BTN           (N),
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP),
        .REPEAT_MASK     (MASK)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_raw   (btn_raw),
        .btn_level (btn_level),
        .btn_pulse (btn_pulse)
    );

    int errors = 0;
    int checks = 0;
    int ec = 0;

    // reference model state
    logic [4:0]    m_level = '0;
    logic [4:0]    m_pulse = '0;
    logic [4:0]    rh1 = '0;
    logic [4:0]    rh2 = '0;
    logic [DB-1:0] win [N];
    int            nwin [N];
    int            rise_at [N];

    // observed DUT activity
    logic [4:0] prev_lvl = '0;
    int pcnt [N];
    int rcnt [N];
    int rise_ec [N];
    int fall_ec [N];
    int lastp_ec [N];
    int pq3 [$];

    typedef struct {
        logic [4:0] raw;
        int         cycles;
        logic [4:0] exp_level;
        int         exp_pulses;
    } seg_t;

    seg_t tbl [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, ec);
        end
    endtask

    // Level toggles once the last DB synchronized samples all disagree with it;
    // pulses on the rise and, for repeat channels, at RD, RD+RP, ... cycles held.
    task automatic model_edge(input logic [4:0] raw, input logic rst);
        logic s;
        logic old;
        int   held;
        for (int ch = 0; ch < N; ch++) begin
            if (rst) begin
                m_level[ch] = 1'b0;
                m_pulse[ch] = 1'b0;
                win[ch]     = '0;
                nwin[ch]    = 0;
            end else begin
                s   = rh2[ch];
                old = m_level[ch];
                win[ch] = {win[ch][DB-2:0], s};
                if (nwin[ch] < DB) nwin[ch]++;
                if (nwin[ch] >= DB && win[ch] == {DB{~old}}) m_level[ch] = ~old;
                if (m_level[ch] && !old) begin
                    rise_at[ch] = ec;
                    m_pulse[ch] = 1'b1;
                end else if (m_level[ch] && MASK[ch]) begin
                    held = ec - rise_at[ch];
                    m_pulse[ch] = (held >= RD) && ((held - RD) % RP == 0);
                end else begin
                    m_pulse[ch] = 1'b0;
                end
            end
        end
        rh2 = rst ? 5'b0 : rh1;
        rh1 = rst ? 5'b0 : raw;
    endtask

    task automatic step(input logic [4:0] raw, input logic rst);
        btn_raw = raw;
        reset   = rst;
        @(posedge clk);
        ec++;
        model_edge(raw, rst);
        #1;
        check("model_level", 32'(btn_level), 32'(m_level));
        check("model_pulse", 32'(btn_pulse), 32'(m_pulse));
        for (int ch = 0; ch < N; ch++) begin
            if (btn_pulse[ch]) begin
                pcnt[ch]++;
                lastp_ec[ch] = ec;
                if (ch == 3) pq3.push_back(ec);
            end
            if (btn_level[ch] && !prev_lvl[ch]) begin
                rcnt[ch]++;
                rise_ec[ch] = ec;
            end
            if (!btn_level[ch] && prev_lvl[ch]) fall_ec[ch] = ec;
        end
        prev_lvl = btn_level;
    endtask

    function automatic int total_pulses();
        int t = 0;
        for (int ch = 0; ch < N; ch++) t += pcnt[ch];
        return t;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0;
        int p;
        int p2;
        int t;
        int r;
        int exp3 [8];
        logic [7:0] bpat;
        logic [4:0] rv;

        for (int ch = 0; ch < N; ch++) begin
            win[ch] = '0; nwin[ch] = 0; rise_at[ch] = 0;
            pcnt[ch] = 0; rcnt[ch] = 0; rise_ec[ch] = -1; fall_ec[ch] = -1; lastp_ec[ch] = -1;
        end
        exp3 = '{0, 10, 13, 16, 19, 22, 25, 28};

        tbl = '{
            '{5'b00001,  3, 5'b00000, 0},
            '{5'b00001,  5, 5'b00001, 1},
            '{5'b00000,  8, 5'b00000, 0},
            '{5'b00100,  2, 5'b00000, 0},
            '{5'b00000,  6, 5'b00000, 0},
            '{5'b10000,  6, 5'b10000, 1},
            '{5'b10000, 10, 5'b10000, 1},
            '{5'b10000,  3, 5'b10000, 1},
            '{5'b00000,  8, 5'b00000, 1},
            '{5'b01010,  7, 5'b01010, 2},
            '{5'b00000,  8, 5'b00000, 0}
        };

        step(5'b00000, 1'b1);
        step(5'b00000, 1'b1);
        check("reset_level", 32'(btn_level), 32'd0);
        check("reset_pulse", 32'(btn_pulse), 32'd0);
        repeat (5) step(5'b00000, 1'b0);

        foreach (tbl[i]) begin
            p = total_pulses();
            repeat (tbl[i].cycles) step(tbl[i].raw, 1'b0);
            check($sformatf("tbl%0d_level", i), 32'(btn_level), 32'(tbl[i].exp_level));
            check($sformatf("tbl%0d_pulses", i), total_pulses() - p, tbl[i].exp_pulses);
        end

        // clean press on channel 0
        c0 = ec;
        p  = pcnt[0];
        repeat (20) step(5'b00001, 1'b0);
        repeat (12) step(5'b00000, 1'b0);
        check("ch0_rise_latency", rise_ec[0] - c0, 6);
        check("ch0_fall_latency", fall_ec[0] - (c0 + 20), 6);
        check("ch0_pulse_count", pcnt[0] - p, 1);
        check("ch0_pulse_align", lastp_ec[0], rise_ec[0]);

        // bounce on channel 1: 3 high, 1 low, 3 high, low
        r    = rcnt[1];
        p    = pcnt[1];
        bpat = 8'b11101110;
        for (int k = 0; k < 8; k++) step({3'b000, bpat[7-k], 1'b0}, 1'b0);
        repeat (10) step(5'b00000, 1'b0);
        check("ch1_bounce_rises", rcnt[1] - r, 0);
        check("ch1_bounce_pulses", pcnt[1] - p, 0);

        // hold channel 3 so its level stays high for 30 cycles
        pq3.delete();
        for (int k = 0; k < 20 && !btn_level[3]; k++) step(5'b01000, 1'b0);
        check("ch3_rise", 32'(btn_level[3]), 32'd1);
        t = rise_ec[3];
        while (ec < t + 24) step(5'b01000, 1'b0);
        repeat (15) step(5'b00000, 1'b0);
        check("ch3_pulse_count", pq3.size(), 8);
        for (int k = 0; k < 8 && k < pq3.size(); k++)
            check($sformatf("ch3_pulse%0d_offset", k), pq3[k] - t, exp3[k]);
        check("ch3_fall_offset", fall_ec[3] - t, 30);

        // long hold on non-repeat channel 0
        p = pcnt[0];
        repeat (40) step(5'b00001, 1'b0);
        repeat (10) step(5'b00000, 1'b0);
        check("ch0_long_hold_pulses", pcnt[0] - p, 1);

        // simultaneous press on channels 2 and 4
        p  = pcnt[2];
        p2 = pcnt[4];
        repeat (10) step(5'b10100, 1'b0);
        check("ch2_ch4_same_cycle", lastp_ec[2], lastp_ec[4]);
        check("ch2_pulse_at_rise", lastp_ec[2], rise_ec[2]);
        repeat (10) step(5'b00000, 1'b0);
        check("ch2_pulse_count", pcnt[2] - p, 1);
        check("ch4_pulse_count", pcnt[4] - p2, 1);

        // reset while channel 4 is held and debounced high
        for (int k = 0; k < 20 && !btn_level[4]; k++) step(5'b10000, 1'b0);
        check("ch4_held_level", 32'(btn_level[4]), 32'd1);
        repeat (3) step(5'b10000, 1'b0);
        step(5'b10000, 1'b1);
        check("midreset_level", 32'(btn_level), 32'd0);
        check("midreset_pulse", 32'(btn_pulse), 32'd0);
        c0 = ec;
        p  = pcnt[4];
        for (int k = 0; k < 20 && !btn_level[4]; k++) step(5'b10000, 1'b0);
        check("midreset_rerise", rise_ec[4] - c0, 6);
        check("midreset_repulse", pcnt[4] - p, 1);
        check("midreset_pulse_align", lastp_ec[4], rise_ec[4]);
        repeat (12) step(5'b00000, 1'b0);

        // randomized bouncing on all channels with occasional resets
        rv = '0;
        for (int n = 0; n < 2000; n++) begin
            for (int ch = 0; ch < N; ch++)
                if ($urandom_range(0, 5) == 0) rv[ch] = ~rv[ch];
            step(rv, ($urandom_range(0, 299) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Input-side front end for the countdown/stopwatch timer.
- Takes raw, asynchronous, bouncy push-button levels (start, stop, delete, increment-seconds, increment-minutes).
- Delivers clean, synchronous, debounced levels and single-cycle press pulses, with hold-to-repeat on the increment buttons.
- Sits between the board pins and the timer state machine / minutes counter, all on the 50 MHz domain.

Parameters:
- N_BTN, 5, number of independent button channels.
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles needed to accept a level change (20 ms at 50 MHz); minimum 2.
- REPEAT_DELAY, 25000000, held cycles after the press pulse before the first repeat pulse (500 ms).
- REPEAT_PERIOD, 5000000, cycles between subsequent repeat pulses (100 ms); minimum 2.
- REPEAT_MASK, 5'b11000, per-channel auto-repeat enable; bit i = 1 enables repeat on channel i.

Ports:
- clk, input, 1, 50 MHz system clock; all logic on its rising edge.
- reset, input, 1, synchronous, active-high reset.
- btn_raw, input, N_BTN, raw asynchronous button levels, 1 = pressed.
- btn_level, output, N_BTN, debounced synchronous level per channel.
- btn_pulse, output, N_BTN, one-cycle pulse per accepted press and per auto-repeat tick.

Behaviour:
- Reset (synchronous, while reset = 1): synchronizer flops, btn_level, btn_pulse and all counters are cleared to 0. Reset has priority over every other event.
- Synchronizer: a 2-flop synchronizer per channel produces sync = btn_raw delayed 2 cycles.
- Debounce counter:
  - Per channel, counts cycles while sync != btn_level.
  - Cleared to 0 in any cycle where sync == btn_level, so a glitch shorter than DEBOUNCE_CYCLES is fully discarded.
  - When the counter equals DEBOUNCE_CYCLES-1 and sync != btn_level, btn_level toggles at that edge and the counter clears.
  - Latency: a clean raw edge reaches btn_level after exactly DEBOUNCE_CYCLES+2 cycles.
- Press pulse: btn_pulse[i] = 1 for exactly the first cycle in which btn_level[i] = 1 (registered rising-edge detect aligned with the level). A release produces no pulse.
- Repeat state machine, per channel with REPEAT_MASK[i] = 1:
  - IDLE: btn_level = 0. On the rising edge of btn_level, go to DELAY with the repeat counter at 0.
  - DELAY: count while held. When the counter reaches REPEAT_DELAY-1, emit a pulse, clear the counter and go to REPEAT.
  - REPEAT: count while held. When the counter reaches REPEAT_PERIOD-1, emit a pulse and clear the counter.
  - Any state: when btn_level falls, go to IDLE immediately with the counter cleared; no pulse is emitted on that cycle.
- Channels with REPEAT_MASK[i] = 0 never leave IDLE and give one pulse per press.
- Channels are fully independent; simultaneous presses on several channels each pulse in their own aligned cycle.
- Reset mid-press: after reset deasserts with the button still held, btn_level is 0, then rises after DEBOUNCE_CYCLES+2 cycles with a fresh press pulse. This is the required behaviour.
- Counter widths are $clog2 of the largest compared value. Counters saturate and never wrap.

Decomposition:
- Shared package (timer_pkg): button index constants BTN_START=0, BTN_STOP=1, BTN_DELETE=2, BTN_INC_SEC=3, BTN_INC_MIN=4; default cycle constants for 50 MHz (20 ms, 500 ms, 100 ms).
- One sub-module, debounce_channel: synchronizer, debounce counter, edge detect and repeat FSM for a single bit, with a REPEAT_EN parameter. It is instantiated N_BTN times in a generate loop; the top is wiring only.

Test Plan (bench uses DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, REPEAT_MASK=5'b11000):
- Clean press on channel 0, held for 20 cycles, then released -> btn_level[0] rises 6 cycles after btn_raw and falls 6 cycles after release; exactly one btn_pulse[0] cycle, coincident with the level rise.
- Bounce on channel 1: high 3 cycles, low 1, high 3, low -> btn_level[1] and btn_pulse[1] stay 0 throughout.
- Hold channel 3 for 30 cycles after btn_level rises:
  - pulses at level-rise cycle t, then t+10, t+13, t+16, ... up to t+28;
  - release -> no further pulses.
- Hold channel 0 (non-repeat) for 40 cycles -> exactly one pulse.
- Press channels 2 and 4 in the same cycle -> pulses on both bits in the same cycle.
- Reset for 1 cycle while channel 4 is held and btn_level[4] = 1:
  - btn_level and btn_pulse are 0 the cycle after reset;
  - btn_level[4] re-rises 6 cycles after reset deassert, with a new pulse.
